// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and default widths for the RAM access controller.
package ram_access_pkg;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  // VERIFY is only reachable when RAM_ACCESS_CTRL_VERIFY_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RESP,
    VERIFY
  } state_e;
endpackage

// File: rtl/ram_access_ctrl_if.sv
// Request/response channels plus the RAM strobe bus of the access controller.
// master: requester and RAM side; slave: the controller itself.
interface ram_access_ctrl_if #(
  parameter int ADDR_W = ram_access_pkg::ADDR_W_DEF,
  parameter int DATA_W = ram_access_pkg::DATA_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mem_cs;
  logic              mem_we;
  logic              mem_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
           mem_cs, mem_we, mem_oe, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
           mem_cs, mem_we, mem_oe, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Initiator for the synchronous single-port RAM: one outstanding request,
// write strobe or RD_LAT-cycle read strobe, then a held read response.
// Optional: RAM_ACCESS_CTRL_VERIFY_EN adds a read-back check after every
// write and a sticky verify_err output.
module ram_access_ctrl
  import ram_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1            // 1..4
) (
  input  logic             clk,
  input  logic             rst,
  ram_access_ctrl_if.slave bus,
  output logic             busy
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
  ,
  output logic             verify_err
`endif
);

  // Down-counter reaches zero on the last strobe cycle of a read.
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  // State, latched request and captured read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && bus.req_valid) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state_q == READ && cnt_q == '0)
        rdata_q <= bus.mem_rdata;
    end
  end

  // Next state and RAM strobes; strobes decode straight from state so a
  // reset drops them without waiting for a clock edge.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_cs    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_oe    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_d = bus.req_we ? WRITE : READ;
          cnt_d   = CNT_INIT;
        end
      end
      WRITE: begin
        bus.mem_cs    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
        state_d = VERIFY;
        cnt_d   = CNT_INIT;
`else
        state_d = IDLE;
`endif
      end
      READ: begin
        bus.mem_cs   = 1'b1;
        bus.mem_oe   = 1'b1;
        bus.mem_addr = addr_q;
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 2'd1;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
      VERIFY: begin
        bus.mem_cs   = 1'b1;
        bus.mem_oe   = 1'b1;
        bus.mem_addr = addr_q;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 2'd1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef RAM_ACCESS_CTRL_VERIFY_EN
  // Sticky flag: read-back differs from what was just written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      verify_err <= 1'b0;
    else if (state_q == VERIFY && cnt_q == '0 && bus.mem_rdata != wdata_q)
      verify_err <= 1'b1;
  end
`endif

  assign bus.rsp_rdata = rdata_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench: DUT with RD_LAT=1 (bus1) and RD_LAT=3 (bus3), each with a
// behavioural RAM whose data is only valid on the RD_LAT-th oe cycle.
module tb_ram_access_ctrl;
  logic clk;
  logic rst1, rst3;
  logic busy1, busy3;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
  logic verr1, verr3;
`endif
  int n_cmp = 0;
  int n_err = 0;

  ram_access_ctrl_if #(.ADDR_W(7), .DATA_W(8)) bus1();
  ram_access_ctrl_if #(.ADDR_W(7), .DATA_W(8)) bus3();

  ram_access_ctrl #(.ADDR_W(7), .DATA_W(8), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .bus(bus1), .busy(busy1)
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    , .verify_err(verr1)
`endif
  );

  ram_access_ctrl #(.ADDR_W(7), .DATA_W(8), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .bus(bus3), .busy(busy3)
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    , .verify_err(verr3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: contents reset to addr ^ 5A.
  logic [7:0] mem1 [128];
  logic [7:0] mem3 [128];
  int ocnt1, ocnt3;

  always @(posedge clk or posedge rst1) begin
    if (rst1) begin
      for (int i = 0; i < 128; i++) mem1[i] <= 8'(i) ^ 8'h5A;
    end else if (bus1.mem_cs && bus1.mem_we) begin
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
      mem1[bus1.mem_addr] <= (bus1.mem_addr == 7'd5) ? ~bus1.mem_wdata : bus1.mem_wdata;
`else
      mem1[bus1.mem_addr] <= bus1.mem_wdata;
`endif
    end
  end

  always @(posedge clk or posedge rst3) begin
    if (rst3) begin
      for (int i = 0; i < 128; i++) mem3[i] <= 8'(i) ^ 8'h5A;
    end else if (bus3.mem_cs && bus3.mem_we) begin
      mem3[bus3.mem_addr] <= bus3.mem_wdata;
    end
  end

  always @(posedge clk) ocnt1 <= bus1.mem_oe ? ocnt1 + 1 : 0;
  always @(posedge clk) ocnt3 <= bus3.mem_oe ? ocnt3 + 1 : 0;

  assign bus1.mem_rdata = (bus1.mem_oe && ocnt1 == 0) ? mem1[bus1.mem_addr] : 8'hEE;
  assign bus3.mem_rdata = (bus3.mem_oe && ocnt3 == 2) ? mem3[bus3.mem_addr] : 8'hEE;

  // Event counters sampled on the falling edge.
  int cs1 = 0, we1 = 0, oe1 = 0, rv1 = 0, ovl1 = 0, oe3 = 0, rv3 = 0;
  always @(negedge clk) begin
    if (bus1.mem_cs) cs1 <= cs1 + 1;
    if (bus1.mem_we) we1 <= we1 + 1;
    if (bus1.mem_oe) oe1 <= oe1 + 1;
    if (bus1.rsp_valid) rv1 <= rv1 + 1;
    if (bus1.mem_we && bus1.mem_oe) ovl1 <= ovl1 + 1;
    if (bus3.mem_oe) oe3 <= oe3 + 1;
    if (bus3.rsp_valid) rv3 <= rv3 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr1(input logic [6:0] a, input logic [7:0] d);
    int n;
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_addr = a; bus1.req_wdata = d;
    n = 0;
    while (!bus1.req_ready && n < 40) begin @(negedge clk); n++; end
    chk("wr_accept", 32'(bus1.req_ready), 1);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    chk("wr_we",   32'(bus1.mem_we), 1);
    chk("wr_cs",   32'(bus1.mem_cs), 1);
    chk("wr_oe",   32'(bus1.mem_oe), 0);
    chk("wr_addr", 32'(bus1.mem_addr), 32'(a));
    chk("wr_data", 32'(bus1.mem_wdata), 32'(d));
`ifndef RAM_ACCESS_CTRL_VERIFY_EN
    @(negedge clk);
    chk("wr_back2back_ready", 32'(bus1.req_ready), 1);
`endif
  endtask

  task automatic rd1(input logic [6:0] a, input int hold, output logic [7:0] d);
    int n;
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = a;
    n = 0;
    while (!bus1.req_ready && n < 40) begin @(negedge clk); n++; end
    chk("rd_accept", 32'(bus1.req_ready), 1);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    bus1.rsp_ready = (hold == 0);
    n = 0;
    while (!bus1.rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("rd_rsp_seen", 32'(bus1.rsp_valid), 1);
    d = bus1.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid",  32'(bus1.rsp_valid), 1);
      chk("bp_stable", 32'(bus1.rsp_rdata), 32'(d));
      chk("bp_ready0", 32'(bus1.req_ready), 0);
    end
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_one_cycle", 32'(bus1.rsp_valid), 0);
  endtask

  initial begin
    int s_cs, s_we, s_oe, s_rv, n;
    logic [7:0] d;
    rst1 = 1'b1; rst3 = 1'b1;
    bus1.req_valid = 0; bus1.req_we = 0; bus1.req_addr = '0; bus1.req_wdata = '0; bus1.rsp_ready = 1;
    bus3.req_valid = 0; bus3.req_we = 0; bus3.req_addr = '0; bus3.req_wdata = '0; bus3.rsp_ready = 1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_req_ready", 32'(bus1.req_ready), 1);
    chk("rst_rsp_valid", 32'(bus1.rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(bus1.rsp_rdata), 0);
    chk("rst_mem_cs",    32'(bus1.mem_cs), 0);
    chk("rst_mem_we",    32'(bus1.mem_we), 0);
    chk("rst_mem_oe",    32'(bus1.mem_oe), 0);
    chk("rst_mem_addr",  32'(bus1.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus1.mem_wdata), 0);
    chk("rst_busy",      32'(busy1), 0);
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    chk("rst_verify_err", 32'(verr1), 0);
`endif
    rst1 = 1'b0; rst3 = 1'b0;

    // Idle for 10 cycles
    s_cs = cs1;
    repeat (10) @(negedge clk);
    chk("idle_cs_cycles", 32'(cs1 - s_cs), 0);
    chk("idle_req_ready", 32'(bus1.req_ready), 1);

    // Write 55 to 12
    s_cs = cs1; s_we = we1; s_rv = rv1;
    wr1(7'd12, 8'd55);
    repeat (5) @(negedge clk);
    chk("wr_we_cycles", 32'(we1 - s_we), 1);
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    chk("wr_cs_cycles", 32'(cs1 - s_cs), 2);
    chk("verify_ok_no_err", 32'(verr1), 0);
`else
    chk("wr_cs_cycles", 32'(cs1 - s_cs), 1);
`endif
    chk("wr_no_rsp", 32'(rv1 - s_rv), 0);

    // Read 12 back
    s_oe = oe1; s_rv = rv1;
    rd1(7'd12, 0, d);
    chk("rd12_data", 32'(d), 32'd55);
    chk("rd12_oe_cycles", 32'(oe1 - s_oe), 1);
    chk("rd12_rsp_cycles", 32'(rv1 - s_rv), 1);

    // Two writes, backpressured read of 8, then read 12
    wr1(7'd8, 8'd44);
    wr1(7'd12, 8'd55);
    rd1(7'd8, 5, d);
    chk("rd8_bp_data", 32'(d), 32'd44);
    rd1(7'd12, 0, d);
    chk("rd12_after_bp", 32'(d), 32'd55);

    // Address 0 and 127 boundaries on RD_LAT=1 (reset contents)
    rd1(7'd0, 0, d);
    chk("rd0_data", 32'(d), 32'h5A);
    rd1(7'd127, 0, d);
    chk("rd127_lat1_data", 32'(d), 32'h25);
    chk("we_oe_overlap", 32'(ovl1), 0);

`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    // Model corrupts address 5: the read-back must flag it
    wr1(7'd5, 8'h3C);
    repeat (4) @(negedge clk);
    chk("verify_err_set", 32'(verr1), 1);
    repeat (3) @(negedge clk);
    chk("verify_err_sticky", 32'(verr1), 1);
`endif

    // RD_LAT=3: read 127
    s_oe = oe3;
    @(negedge clk);
    bus3.req_valid = 1'b1; bus3.req_we = 1'b0; bus3.req_addr = 7'd127;
    @(negedge clk);
    bus3.req_valid = 1'b0;
    n = 0;
    while (!bus3.rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("lat3_rsp_seen", 32'(bus3.rsp_valid), 1);
    chk("lat3_rd127_data", 32'(bus3.rsp_rdata), 32'h25);
    @(negedge clk);
    chk("lat3_oe_cycles", 32'(oe3 - s_oe), 3);
    chk("lat3_rsp_done", 32'(bus3.rsp_valid), 0);

    // Reset in the middle of a RD_LAT=3 read
    @(negedge clk);
    bus3.req_valid = 1'b1; bus3.req_we = 1'b0; bus3.req_addr = 7'd20;
    @(negedge clk);
    bus3.req_valid = 1'b0;
    chk("midrst_oe_before", 32'(bus3.mem_oe), 1);
    #2 rst3 = 1'b1;
    #1;
    chk("midrst_oe_async", 32'(bus3.mem_oe), 0);
    chk("midrst_cs_async", 32'(bus3.mem_cs), 0);
    chk("midrst_busy",     32'(busy3), 0);
    @(negedge clk);
    rst3 = 1'b0;
    s_rv = rv3;
    repeat (8) @(negedge clk);
    chk("midrst_no_rsp", 32'(rv3 - s_rv), 0);
    chk("midrst_ready",  32'(bus3.req_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Initiator side of the lab's synchronous single-port RAM interface (cs/we/oe/address/data_in/data_out).
- Accepts read/write requests on a valid/ready channel and sequences the RAM strobes.
- Captures read data after a fixed latency and returns it on a valid/ready response channel.
- Sits between a test sequencer or CPU-side logic and the RAM block.

Parameters:
- ADDR_W, 7, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, cycles from mem_oe asserted to mem_rdata valid; legal range 1-4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data.
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write enable.
- mem_oe  out  1  RAM output enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM data_in.
- mem_rdata  in  DATA_W  RAM data_out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; req_ready=1; rsp_valid=0; all mem_* and rsp_rdata=0; busy=0.
- A request is accepted on a cycle with req_valid & req_ready. req_addr, req_we and req_wdata are registered at acceptance.
- req_ready=1 only in IDLE, so at most one transaction is outstanding.
- FSM states and transitions:
  - IDLE: on accept with we=1 -> WRITE; on accept with we=0 -> READ.
  - WRITE: exactly one cycle with mem_cs=1, mem_we=1, mem_oe=0, mem_addr/mem_wdata = latched values -> IDLE. Writes produce no response.
  - READ: mem_cs=1, mem_oe=1, mem_we=0, mem_addr latched. Hold for RD_LAT cycles using a down-counter. On the final cycle register mem_rdata into rsp_rdata -> RESP.
  - RESP: mem_cs/mem_oe=0; rsp_valid=1 and rsp_rdata stable until rsp_valid & rsp_ready -> IDLE.
- mem_we and mem_oe are never high in the same cycle. mem_cs is low in IDLE and RESP.
- Throughput: back-to-back writes every 2 cycles (accept, strobe). Read takes 1 + RD_LAT + (≥1 in RESP) cycles.
- rsp_ready held high: rsp_valid lasts exactly 1 cycle. Backpressure holds RESP indefinitely; no new request is accepted meanwhile.
- req_valid while busy: ignored (req_ready=0). The requester must hold it.
- Address wrap: none. Address is passed through verbatim; full ADDR_W range is legal (0 to 2^ADDR_W-1).
- rst mid-transaction: the transaction is aborted, mem strobes drop immediately (async), and any pending response is discarded.

Optional Feature:
- Macro: RAM_ACCESS_CTRL_VERIFY_EN.
- Defined:
  - Every WRITE is followed by an automatic VERIFY read of the same address (same timing as READ, no response issued).
  - Read data is compared with the latched wdata. On mismatch, sticky output verify_err (1 bit, reset 0) is set and cleared only by rst.
  - The added port verify_err exists only under the macro.
  - Write cost rises to 2 + RD_LAT cycles.
- Undefined: no VERIFY state, no verify_err port, write timing as above.

Decomposition:
- Package ram_access_pkg holds the state enum (IDLE, WRITE, READ, RESP, VERIFY) and the default widths ADDR_W_DEF=7 and DATA_W_DEF=8.
- Single module; no sub-module. The latency counter is inline.

Test Plan:
- Reset then idle: all outputs 0 except req_ready=1; mem_cs stays 0 for 10 cycles.
- Write 55 to address 12: exactly one cycle mem_cs=1, mem_we=1, mem_addr=12, mem_wdata=55; rsp_valid stays 0.
- Read address 12 after that write (behavioural RAM model, RD_LAT=1): mem_oe high 1 cycle, then rsp_valid=1 with rsp_rdata=55.
- Write 44 to address 8 and 55 to address 12, then read 8 with rsp_ready low for 5 cycles: rsp_valid held and rsp_rdata=44 stable; req_ready=0 throughout; next read of 12 returns 55.
- RD_LAT=3, read address 127: mem_oe high exactly 3 cycles; the value at address 127 is returned.
- rst pulsed during READ: mem_oe drops asynchronously, no rsp_valid appears. With VERIFY_EN and the model corrupting address 5, a write to address 5 sets verify_err=1.
